// File: rtl/uart_core.sv
// uart_core: full-duplex UART with independent TX and RX engines sharing one 16x oversample tick.
// Configurable data width, parity and stop bits; RX samples at bit centres; per-word error flags.
// Optional feature: define UART_RX_FIFO_EN to buffer received words in a RX_FIFO_DEPTH-entry FIFO.
// Without it, received words sit in a single holding register.
module uart_core #(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned BAUD_RATE     = 115200,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned PARITY_MODE   = 1,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx,
  input  logic                  rx,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_overrun
);

  localparam int unsigned OsDiv = CLK_FREQ / (16 * BAUD_RATE);
  localparam int unsigned OsW   = (OsDiv > 1) ? $clog2(OsDiv) : 1;
  localparam logic [4:0]  StopLast = 5'(16 * STOP_BITS - 1);
  localparam logic [3:0]  LastBit  = 4'(DATA_WIDTH - 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  function automatic logic par_of(input logic [DATA_WIDTH-1:0] d);
    return (PARITY_MODE == 2) ? ~^d : ^d;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Oversample tick
  // ---------------------------------------------------------------------------------------------
  logic [OsW-1:0] os_cnt_q;
  logic           tick;

  assign tick = (os_cnt_q == OsW'(OsDiv - 1));

  // Free-running divider, one-cycle tick at wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) os_cnt_q <= '0;
    else      os_cnt_q <= tick ? '0 : os_cnt_q + 1'b1;
  end

  // ---------------------------------------------------------------------------------------------
  // TX engine
  // ---------------------------------------------------------------------------------------------
  logic [2:0]            tx_state_q, tx_state_d;
  logic [4:0]            tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_q, tx_d;

  assign tx_ready = (tx_state_q == StIdle);
  assign tx       = tx_q;

  // TX next state; the line value is registered so it changes exactly at bit boundaries.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    unique case (tx_state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          tx_state_d = StStart;
          tx_shift_d = tx_data;
          tx_par_d   = par_of(tx_data);
          tx_cnt_d   = '0;
          tx_d       = 1'b0;
        end
      end
      StStart: begin
        if (tick) begin
          if (tx_cnt_q == 5'd15) begin
            tx_state_d = StData;
            tx_cnt_d   = '0;
            tx_bit_d   = '0;
            tx_d       = tx_shift_q[0];
          end else begin
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          if (tx_cnt_q == 5'd15) begin
            tx_cnt_d = '0;
            if (tx_bit_q == LastBit) begin
              if (PARITY_MODE != 0) begin
                tx_state_d = StParity;
                tx_d       = tx_par_q;
              end else begin
                tx_state_d = StStop;
                tx_d       = 1'b1;
              end
            end else begin
              tx_bit_d   = tx_bit_q + 4'd1;
              tx_shift_d = tx_shift_q >> 1;
              tx_d       = tx_shift_q[1];
            end
          end else begin
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
      StParity: begin
        if (tick) begin
          if (tx_cnt_q == 5'd15) begin
            tx_state_d = StStop;
            tx_cnt_d   = '0;
            tx_d       = 1'b1;
          end else begin
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          if (tx_cnt_q == StopLast) begin
            tx_state_d = StIdle;
            tx_cnt_d   = '0;
          end else begin
            tx_cnt_d = tx_cnt_q + 5'd1;
          end
        end
      end
      default: begin
        tx_state_d = StIdle;
        tx_d       = 1'b1;
      end
    endcase
  end

  // TX state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= StIdle;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
      tx_q       <= tx_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // RX engine
  // ---------------------------------------------------------------------------------------------
  logic [1:0]            rx_sync_q;
  logic                  rx_s;
  logic [2:0]            rx_state_q, rx_state_d;
  logic [3:0]            rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic                  rx_perr_q, rx_perr_d;
  logic                  rx_brk_q, rx_brk_d;
  logic                  rx_done;
  logic                  rx_ferr_now;

  assign rx_s = rx_sync_q[1];

  // Two-flop synchroniser; resets to the idle line level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_sync_q <= 2'b11;
    else      rx_sync_q <= {rx_sync_q[0], rx};
  end

  // RX next state: start validated at mid-bit, then every sample lands on a bit centre.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    rx_perr_d   = rx_perr_q;
    rx_brk_d    = rx_brk_q;
    rx_done     = 1'b0;
    rx_ferr_now = 1'b0;
    unique case (rx_state_q)
      StIdle: begin
        if (rx_brk_q) begin
          // A held-low line after a framing error must not look like a new start bit.
          if (rx_s) rx_brk_d = 1'b0;
        end else if (tick && !rx_s) begin
          rx_state_d = StStart;
          rx_cnt_d   = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (rx_cnt_q == 4'd7) begin
            rx_cnt_d = '0;
            if (!rx_s) begin
              rx_state_d = StData;
              rx_bit_d   = '0;
              rx_perr_d  = 1'b0;
            end else begin
              rx_state_d = StIdle;
            end
          end else begin
            rx_cnt_d = rx_cnt_q + 4'd1;
          end
        end
      end
      StData: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_shift_d = {rx_s, rx_shift_q[DATA_WIDTH-1:1]};
            if (rx_bit_q == LastBit) begin
              rx_state_d = (PARITY_MODE != 0) ? StParity : StStop;
            end else begin
              rx_bit_d = rx_bit_q + 4'd1;
            end
          end
        end
      end
      StParity: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_perr_d  = (rx_s != par_of(rx_shift_q));
            rx_state_d = StStop;
          end
        end
      end
      StStop: begin
        if (tick) begin
          rx_cnt_d = rx_cnt_q + 4'd1;
          if (rx_cnt_q == 4'd15) begin
            rx_done     = 1'b1;
            rx_ferr_now = !rx_s;
            rx_brk_d    = !rx_s;
            rx_state_d  = StIdle;
          end
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // RX state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= StIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_perr_q  <= 1'b0;
      rx_brk_q   <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_perr_q  <= rx_perr_d;
      rx_brk_q   <= rx_brk_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // RX output stage
  // ---------------------------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(RX_FIFO_DEPTH);

  logic [DATA_WIDTH-1:0]    fifo_data_q [RX_FIFO_DEPTH];
  logic [RX_FIFO_DEPTH-1:0] fifo_perr_q, fifo_ferr_q, fifo_ovr_q;
  logic [PtrW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]          wr_idx, rd_idx, newest_idx;
  logic                     empty, full, push, pop;

  assign wr_idx     = wr_ptr_q[PtrW-1:0];
  assign rd_idx     = rd_ptr_q[PtrW-1:0];
  assign newest_idx = wr_idx - PtrW'(1);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) && (wr_idx == rd_idx);
  assign pop        = !empty && rx_ready;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the write.
  assign push       = rx_done && (!full || pop);

  // FIFO pointer next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  end

  // FIFO storage; a dropped word marks the newest stored entry as overrun.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(RX_FIFO_DEPTH); i++) fifo_data_q[i] <= '0;
      fifo_perr_q <= '0;
      fifo_ferr_q <= '0;
      fifo_ovr_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        fifo_data_q[wr_idx] <= rx_shift_q;
        fifo_perr_q[wr_idx] <= rx_perr_q;
        fifo_ferr_q[wr_idx] <= rx_ferr_now;
        fifo_ovr_q[wr_idx]  <= 1'b0;
      end else if (rx_done) begin
        fifo_ovr_q[newest_idx] <= 1'b1;
      end
    end
  end

  assign rx_valid      = !empty;
  assign rx_data       = fifo_data_q[rd_idx];
  assign rx_parity_err = fifo_perr_q[rd_idx];
  assign rx_frame_err  = fifo_ferr_q[rd_idx];
  assign rx_overrun    = fifo_ovr_q[rd_idx];
`else
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_perr_q, hold_perr_d;
  logic                  hold_ferr_q, hold_ferr_d;
  logic                  hold_ovr_q, hold_ovr_d;
  logic                  rx_hs;

  assign rx_hs = hold_valid_q && rx_ready;

  // Holding register: a completion alongside a handshake replaces the word without overrun.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_perr_d  = hold_perr_q;
    hold_ferr_d  = hold_ferr_q;
    hold_ovr_d   = hold_ovr_q;
    if (rx_done) begin
      if (!hold_valid_q || rx_hs) begin
        hold_valid_d = 1'b1;
        hold_data_d  = rx_shift_q;
        hold_perr_d  = rx_perr_q;
        hold_ferr_d  = rx_ferr_now;
        hold_ovr_d   = 1'b0;
      end else begin
        hold_ovr_d = 1'b1;
      end
    end else if (rx_hs) begin
      hold_valid_d = 1'b0;
      hold_perr_d  = 1'b0;
      hold_ferr_d  = 1'b0;
      hold_ovr_d   = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_perr_q  <= 1'b0;
      hold_ferr_q  <= 1'b0;
      hold_ovr_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_perr_q  <= hold_perr_d;
      hold_ferr_q  <= hold_ferr_d;
      hold_ovr_q   <= hold_ovr_d;
    end
  end

  assign rx_valid      = hold_valid_q;
  assign rx_data       = hold_data_q;
  assign rx_parity_err = hold_perr_q;
  assign rx_frame_err  = hold_ferr_q;
  assign rx_overrun    = hold_ovr_q;
`endif

endmodule
